sram_sched: RTL and testbench

- Single-port scheduler for the board's 16-bit asynchronous SRAM.
- Shares the SRAM among three requesters: the video fetcher, the CPU core and the host/JTAG loader.
- Sequences every access as a fixed-length SRAM cycle.
- Owns all SRAM strobes, byte lanes and data-bus direction; it replaces the ad-hoc combinational muxing in the top level.

---
 rtl/sram_sched.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_sram_sched.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_sched.sv
// sram_sched: single-port scheduler for the board's 16-bit asynchronous SRAM.
// Optional bus hold for the host is enabled by defining SRAM_SCHED_HOLD_EN.
module sram_sched #(
    parameter int unsigned ACC_CYCLES    = 2,
    parameter logic [4:0]  VID_PAGE      = 5'b00001,
    parameter int unsigned HOST_MAX_WAIT = 64
) (
    input  logic        clk25,
    input  logic        reset_in,
    input  logic        vid_req,
    input  logic [12:0] vid_addr,
    output logic [15:0] vid_data,
    output logic        vid_valid,
    output logic        vid_overrun,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_byte,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [17:0] host_addr,
    input  logic [15:0] host_wdata,
    output logic [15:0] host_rdata,
    output logic        host_ack,
    input  logic        host_hold,
    output logic        host_hlda,
    output logic [17:0] ram_addr,
    input  logic [15:0] ram_dq_in,
    output logic [15:0] ram_dq_out,
    output logic        ram_dq_oe,
    output logic        ram_oe_n,
    output logic        ram_we_n,
    output logic        ram_lb_n,
    output logic        ram_ub_n
);

    localparam int unsigned PW = (ACC_CYCLES > 2) ? $clog2(ACC_CYCLES) : 1;
    localparam int unsigned WW = $clog2(HOST_MAX_WAIT + 1);
    localparam logic [PW-1:0] LAST_PHASE = PW'(ACC_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(HOST_MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_VID,
        SRC_CPU,
        SRC_HOST
    } src_t;

    state_t        state;
    state_t        state_nx;
    logic [PW-1:0] phase;
    logic [PW-1:0] phase_nx;
    src_t          sel;
    src_t          gnt;
    logic          we_q;

    logic          vid_pend;
    logic [12:0]   vid_addr_q;
    logic [WW-1:0] host_wait;
    logic          host_urgent;
    logic          host_busy;
    logic          hold_blk;

    logic [17:0]   acc_addr;
    logic          acc_we;
    logic          acc_lb_n;
    logic          acc_ub_n;
    logic [15:0]   acc_wdata;
    logic          last_phase;

    assign last_phase  = (state == ACC) && (phase == LAST_PHASE);
    assign host_urgent = host_req && (host_wait >= WAIT_MAX);
    assign host_busy   = (state != IDLE) && (gnt == SRC_HOST);

    // Arbitration: only decided while idle, fixed priority with host aging.
    always_comb begin
        sel = SRC_NONE;
        if (state == IDLE) begin
            if (vid_pend || vid_req) begin
                sel = SRC_VID;
            end else if (host_urgent) begin
                sel = SRC_HOST;
            end else if (cpu_req && !hold_blk) begin
                sel = SRC_CPU;
            end else if (host_req) begin
                sel = SRC_HOST;
            end
        end
    end

    // Address, direction, lanes and write data of the access being granted.
    always_comb begin
        acc_addr  = '0;
        acc_we    = 1'b0;
        acc_lb_n  = 1'b0;
        acc_ub_n  = 1'b0;
        acc_wdata = '0;
        case (sel)
            SRC_VID: begin
                acc_addr = {VID_PAGE, vid_pend ? vid_addr_q : vid_addr};
            end
            SRC_CPU: begin
                acc_addr = {3'b000, cpu_addr[15:1]};
                acc_we   = cpu_we;
                if (cpu_byte) begin
                    acc_lb_n  = cpu_addr[0];
                    acc_ub_n  = ~cpu_addr[0];
                    acc_wdata = {2{cpu_wdata[7:0]}};
                end else begin
                    acc_wdata = cpu_wdata;
                end
            end
            SRC_HOST: begin
                acc_addr  = host_addr;
                acc_we    = host_we;
                acc_wdata = host_wdata;
            end
            default: begin
            end
        endcase
    end

    // FSM next state: IDLE -> ACC (ACC_CYCLES phases) -> DONE -> IDLE.
    always_comb begin
        state_nx = state;
        phase_nx = phase;
        unique case (state)
            IDLE: begin
                if (sel != SRC_NONE) begin
                    state_nx = ACC;
                    phase_nx = '0;
                end
            end
            ACC: begin
                if (phase == LAST_PHASE) begin
                    state_nx = DONE;
                end else begin
                    phase_nx = phase + PW'(1);
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // FSM state and phase register.
    always_ff @(posedge clk25) begin
        if (reset_in) begin
            state <= IDLE;
            phase <= '0;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
        end
    end

    // SRAM pins: set up at grant, write strobe from phase 1, all off at end.
    always_ff @(posedge clk25) begin
        if (reset_in) begin
            gnt        <= SRC_NONE;
            we_q       <= 1'b0;
            ram_addr   <= '0;
            ram_dq_out <= '0;
            ram_dq_oe  <= 1'b0;
            ram_oe_n   <= 1'b1;
            ram_we_n   <= 1'b1;
            ram_lb_n   <= 1'b1;
            ram_ub_n   <= 1'b1;
        end else begin
            if (sel != SRC_NONE) begin
                gnt        <= sel;
                we_q       <= acc_we;
                ram_addr   <= acc_addr;
                ram_dq_out <= acc_wdata;
                ram_dq_oe  <= acc_we;
                ram_oe_n   <= acc_we;
                ram_we_n   <= 1'b1;
                ram_lb_n   <= acc_lb_n;
                ram_ub_n   <= acc_ub_n;
            end else if (last_phase) begin
                ram_dq_oe <= 1'b0;
                ram_oe_n  <= 1'b1;
                ram_we_n  <= 1'b1;
                ram_lb_n  <= 1'b1;
                ram_ub_n  <= 1'b1;
            end else if (state == ACC && we_q) begin
                ram_we_n <= 1'b0;
            end
        end
    end

    // Capture read data at the end of the last phase; pulse ack in DONE.
    always_ff @(posedge clk25) begin
        if (reset_in) begin
            vid_valid  <= 1'b0;
            cpu_ack    <= 1'b0;
            host_ack   <= 1'b0;
            vid_data   <= '0;
            cpu_rdata  <= '0;
            host_rdata <= '0;
        end else begin
            vid_valid <= 1'b0;
            cpu_ack   <= 1'b0;
            host_ack  <= 1'b0;
            if (last_phase) begin
                case (gnt)
                    SRC_VID: begin
                        vid_valid <= 1'b1;
                        vid_data  <= ram_dq_in;
                    end
                    SRC_CPU: begin
                        cpu_ack <= 1'b1;
                        if (!we_q) begin
                            cpu_rdata <= ram_dq_in;
                        end
                    end
                    SRC_HOST: begin
                        host_ack <= 1'b1;
                        if (!we_q) begin
                            host_rdata <= ram_dq_in;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Video request latch: newest address wins, losing one is sticky overrun.
    always_ff @(posedge clk25) begin
        if (reset_in) begin
            vid_pend    <= 1'b0;
            vid_addr_q  <= '0;
            vid_overrun <= 1'b0;
        end else begin
            if (vid_req) begin
                vid_addr_q <= vid_addr;
                if (vid_pend && sel != SRC_VID) begin
                    vid_overrun <= 1'b1;
                end
            end
            if (sel == SRC_VID) begin
                vid_pend <= vid_pend && vid_req;
            end else begin
                vid_pend <= vid_pend || vid_req;
            end
        end
    end

    // Host aging counter: counts waiting clocks, saturates, clears on grant.
    always_ff @(posedge clk25) begin
        if (reset_in) begin
            host_wait <= '0;
        end else if (sel == SRC_HOST) begin
            host_wait <= '0;
        end else if (host_req && !host_busy && host_wait != WAIT_MAX) begin
            host_wait <= host_wait + WW'(1);
        end
    end

`ifdef SRAM_SCHED_HOLD_EN
    logic hlda_q;
    logic cpu_busy;

    assign hold_blk  = host_hold;
    assign cpu_busy  = (state != IDLE) && (gnt == SRC_CPU);
    assign host_hlda = hlda_q;

    // Hold acknowledge once no CPU access is in flight; drops after hold.
    always_ff @(posedge clk25) begin
        if (reset_in) begin
            hlda_q <= 1'b0;
        end else if (!host_hold) begin
            hlda_q <= 1'b0;
        end else if (!cpu_busy && sel != SRC_CPU) begin
            hlda_q <= 1'b1;
        end
    end
`else
    logic unused_hold;

    assign hold_blk    = 1'b0;
    assign host_hlda   = 1'b0;
    assign unused_hold = host_hold;
`endif

endmodule

// File: tb/tb_sram_sched.sv
// tb_sram_sched: randomized and directed checks of sram_sched against
// a transaction-level reference model and a pin-level SRAM model.
module tb_sram_sched;

    localparam int AC   = 2;
    localparam int HMW  = 64;
    localparam int SLOT = AC + 2;

    logic        clk25 = 1'b0;
    logic        reset_in;
    logic        vid_req;
    logic [12:0] vid_addr;
    logic [15:0] vid_data;
    logic        vid_valid;
    logic        vid_overrun;
    logic        cpu_req;
    logic        cpu_we;
    logic        cpu_byte;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;
    logic        host_req;
    logic        host_we;
    logic [17:0] host_addr;
    logic [15:0] host_wdata;
    logic [15:0] host_rdata;
    logic        host_ack;
    logic        host_hold;
    logic        host_hlda;
    logic [17:0] ram_addr;
    logic [15:0] ram_dq_in;
    logic [15:0] ram_dq_out;
    logic        ram_dq_oe;
    logic        ram_oe_n;
    logic        ram_we_n;
    logic        ram_lb_n;
    logic        ram_ub_n;

    always #20 clk25 = ~clk25;

    sram_sched dut (
        .clk25(clk25), .reset_in(reset_in),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
        .vid_valid(vid_valid), .vid_overrun(vid_overrun),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte(cpu_byte),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ack(cpu_ack),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
        .host_hold(host_hold), .host_hlda(host_hlda),
        .ram_addr(ram_addr), .ram_dq_in(ram_dq_in), .ram_dq_out(ram_dq_out),
        .ram_dq_oe(ram_dq_oe), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
        .ram_lb_n(ram_lb_n), .ram_ub_n(ram_ub_n)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // pin-level SRAM: disabled lanes read back as zero
    logic [15:0] sram_mem [0:262143];
    logic [15:0] ref_mem  [0:262143];

    always_comb begin
        ram_dq_in = 16'h0000;
        if (!ram_oe_n) begin
            ram_dq_in = sram_mem[ram_addr] & {{8{~ram_ub_n}}, {8{~ram_lb_n}}};
        end
    end

    // pin statistics for directed tests
    int          oe_cnt;
    int          we_cnt;
    logic [17:0] st_addr;
    logic [15:0] st_dout;
    logic        st_lb_n;
    logic        st_ub_n;

    task automatic clr_stats();
        oe_cnt = 0;
        we_cnt = 0;
    endtask

    // reference model: one access per SLOT clocks, ack on its last-but-one
    int          busy = 0;
    int          cur = 0;
    logic        cur_we = 1'b0;
    logic [15:0] cur_rd = '0;
    logic        m_vpend = 1'b0;
    logic [12:0] m_vaddr = '0;
    logic        m_ovr = 1'b0;
    int          hwait = 0;
    logic        e_cack = 1'b0, e_hack = 1'b0, e_vval = 1'b0;
    logic        e_cchk = 1'b0, e_hchk = 1'b0;
    logic [15:0] e_crd = '0, e_hrd = '0, e_vd = '0;

    always @(posedge clk25) begin : model
        logic        h_in;
        int          g;
        logic [17:0] a;
        logic [15:0] m;
        e_cack = 1'b0;
        e_hack = 1'b0;
        e_vval = 1'b0;
        e_cchk = 1'b0;
        e_hchk = 1'b0;
        if (reset_in) begin
            busy = 0;
            cur = 0;
            m_vpend = 1'b0;
            m_ovr = 1'b0;
            hwait = 0;
        end else begin
            h_in = (busy > 0) && (cur == 3);
            g = 0;
            if (busy > 0) begin
                busy--;
                if (busy == 1) begin
                    case (cur)
                        1: begin e_vval = 1'b1; e_vd = cur_rd; end
                        2: begin e_cack = 1'b1; e_cchk = !cur_we; e_crd = cur_rd; end
                        3: begin e_hack = 1'b1; e_hchk = !cur_we; e_hrd = cur_rd; end
                        default: ;
                    endcase
                end
            end else begin
                if (m_vpend || vid_req) g = 1;
                else if (host_req && hwait >= HMW) g = 3;
                else if (cpu_req) g = 2;
                else if (host_req) g = 3;
                if (g == 1) begin
                    a = {5'b00001, m_vpend ? m_vaddr : vid_addr};
                    cur_we = 1'b0;
                    cur_rd = ref_mem[a];
                end else if (g == 2) begin
                    a = {3'b000, cpu_addr[15:1]};
                    cur_we = cpu_we;
                    m = ref_mem[a];
                    if (cpu_we) begin
                        if (!cpu_byte) m = cpu_wdata;
                        else if (cpu_addr[0]) m[15:8] = cpu_wdata[7:0];
                        else m[7:0] = cpu_wdata[7:0];
                        ref_mem[a] = m;
                    end else if (!cpu_byte) cur_rd = m;
                    else if (cpu_addr[0]) cur_rd = {m[15:8], 8'h00};
                    else cur_rd = {8'h00, m[7:0]};
                end else if (g == 3) begin
                    cur_we = host_we;
                    if (host_we) ref_mem[host_addr] = host_wdata;
                    else cur_rd = ref_mem[host_addr];
                end
                if (g != 0) begin
                    busy = AC + 1;
                    cur = g;
                end
            end
            if (vid_req && m_vpend && g != 1) m_ovr = 1'b1;
            if (g == 1) m_vpend = m_vpend && vid_req;
            else m_vpend = m_vpend || vid_req;
            if (vid_req) m_vaddr = vid_addr;
            if (g == 3) hwait = 0;
            else if (host_req && !h_in && hwait < HMW) hwait++;
        end
    end

    // mid-cycle monitor: compare against the model, run the SRAM write port
    always @(negedge clk25) begin
        chk("cpu_ack", cpu_ack, e_cack);
        chk("host_ack", host_ack, e_hack);
        chk("vid_valid", vid_valid, e_vval);
        chk("vid_overrun", vid_overrun, m_ovr);
        chk("bus_contention", ram_dq_oe & ~ram_oe_n, 0);
        if (e_cchk) chk("cpu_rdata", cpu_rdata, e_crd);
        if (e_hchk) chk("host_rdata", host_rdata, e_hrd);
        if (e_vval) chk("vid_data", vid_data, e_vd);
`ifndef SRAM_SCHED_HOLD_EN
        chk("host_hlda", host_hlda, 0);
`endif
        if (!ram_oe_n) oe_cnt++;
        if (!ram_oe_n || !ram_we_n) begin
            st_addr = ram_addr;
            st_dout = ram_dq_out;
            st_lb_n = ram_lb_n;
            st_ub_n = ram_ub_n;
        end
        if (!ram_we_n) begin
            we_cnt++;
            chk("dq_oe_on_write", ram_dq_oe, 1);
            if (!ram_lb_n) sram_mem[ram_addr][7:0] = ram_dq_out[7:0];
            if (!ram_ub_n) sram_mem[ram_addr][15:8] = ram_dq_out[15:8];
        end
    end

    task automatic wait_pulse(input int which, input int limit, output int lat);
        lat = 0;
        for (int i = 1; i <= limit && lat == 0; i++) begin
            @(negedge clk25);
            if ((which == 0 && cpu_ack) || (which == 1 && host_ack) ||
                (which == 2 && vid_valid)) lat = i;
        end
    endtask

    task automatic preload(input logic [17:0] a, input logic [15:0] d);
        sram_mem[a] = d;
        ref_mem[a] = d;
    endtask

    task automatic cpu_set(input logic we, input logic bt,
                           input logic [15:0] a, input logic [15:0] d);
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_byte = bt;
        cpu_addr = a;
        cpu_wdata = d;
    endtask

    initial begin
        int lat;
        int nack;
        int gedge;
        reset_in = 1'b1;
        vid_req = 0; vid_addr = 0;
        cpu_req = 0; cpu_we = 0; cpu_byte = 0; cpu_addr = 0; cpu_wdata = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        host_hold = 0;
        st_addr = 0; st_dout = 0; st_lb_n = 1; st_ub_n = 1;
        clr_stats();
        for (int i = 0; i < 262144; i++) begin
            sram_mem[i] = 16'(i) ^ 16'h5A5A;
            ref_mem[i] = 16'(i) ^ 16'h5A5A;
        end
        repeat (3) @(negedge clk25);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_dq_out", ram_dq_out, 0);
        chk("rst_dq_oe", ram_dq_oe, 0);
        chk("rst_strobes", {ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n}, 4'hF);
        chk("rst_data", {cpu_rdata, host_rdata}, 0);
        chk("rst_vid_data", vid_data, 0);
        chk("rst_hlda", host_hlda, 0);
        reset_in = 1'b0;
        repeat (2) @(negedge clk25);

        // CPU word read on an idle bus
        preload(18'h00200, 16'h1234);
        cpu_set(0, 0, 16'h0400, 16'h0);
        clr_stats();
        wait_pulse(0, 20, lat);
        cpu_req = 0;
        chk("rd_latency", lat, AC + 1);
        chk("rd_addr", st_addr, 18'h00200);
        chk("rd_oe_clocks", oe_cnt, AC);
        chk("rd_we_clocks", we_cnt, 0);
        chk("rd_lanes", {st_lb_n, st_ub_n}, 2'b00);
        chk("rd_data", cpu_rdata, 16'h1234);

        // CPU byte write to an odd address
        repeat (2) @(negedge clk25);
        preload(18'h00100, 16'h1111);
        cpu_set(1, 1, 16'o001001, 16'h33A5);
        clr_stats();
        wait_pulse(0, 20, lat);
        cpu_req = 0;
        chk("bw_addr", st_addr, 18'h00100);
        chk("bw_lanes", {st_lb_n, st_ub_n}, 2'b10);
        chk("bw_we_clocks", we_cnt, AC - 1);
        chk("bw_oe_clocks", oe_cnt, 0);
        chk("bw_dout", st_dout, 16'hA5A5);
        chk("bw_sram", sram_mem[18'h00100], 16'hA511);

        // simultaneous video and CPU: video first
        repeat (2) @(negedge clk25);
        preload(18'h02ABC, 16'hC0DE);
        vid_req = 1; vid_addr = 13'h0ABC;
        cpu_set(0, 0, 16'h1000, 16'h0);
        @(negedge clk25);
        vid_req = 0;
        wait_pulse(2, 20, lat);
        chk("vc_vid_latency", lat + 1, AC + 1);
        chk("vc_vid_addr", st_addr, 18'h02ABC);
        chk("vc_vid_data", vid_data, 16'hC0DE);
        wait_pulse(0, 20, lat);
        cpu_req = 0;
        chk("vc_cpu_after_vid", lat, SLOT);

        // two video requests while the CPU holds the bus
        repeat (2) @(negedge clk25);
        preload(18'h02111, 16'hAAAA);
        preload(18'h02222, 16'hBBBB);
        cpu_set(0, 0, 16'h2000, 16'h0);
        @(negedge clk25);
        vid_req = 1; vid_addr = 13'h0111;
        @(negedge clk25);
        vid_addr = 13'h0222;
        @(negedge clk25);
        vid_req = 0;
        cpu_req = 0;
        nack = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk25);
            if (vid_valid) nack++;
        end
        chk("ovr_flag", vid_overrun, 1);
        chk("ovr_one_fetch", nack, 1);
        chk("ovr_addr", st_addr, 18'h02222);
        chk("ovr_data", vid_data, 16'hBBBB);

        // host aging against a continuously requesting CPU
        repeat (2) @(negedge clk25);
        cpu_set(0, 0, 16'h0400, 16'h0);
        host_req = 1; host_we = 0; host_addr = 18'h3FFFF;
        preload(18'h3FFFF, 16'h600D);
        gedge = ((HMW + SLOT - 1) / SLOT) * SLOT;
        nack = 0;
        lat = 0;
        for (int i = 1; i <= 300 && lat == 0; i++) begin
            @(negedge clk25);
            if (cpu_ack) nack++;
            if (host_ack) lat = i;
        end
        host_req = 0;
        cpu_req = 0;
        chk("age_host_latency", lat, gedge + AC + 1);
        chk("age_cpu_acks", nack, gedge / SLOT);
        chk("age_host_data", host_rdata, 16'h600D);

        // reset in the middle of a CPU write
        repeat (2) @(negedge clk25);
        cpu_set(1, 0, 16'h0800, 16'hBEEF);
        repeat (2) @(negedge clk25);
        reset_in = 1;
        cpu_req = 0;
        @(negedge clk25);
        chk("rmid_strobes", {ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n}, 4'hF);
        chk("rmid_dq_oe", ram_dq_oe, 0);
        chk("rmid_ack", cpu_ack, 0);
        chk("rmid_overrun", vid_overrun, 0);
        reset_in = 0;
        @(negedge clk25);
        chk("rmid_no_late_ack", cpu_ack, 0);

        // randomized traffic from all three requesters
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk25);
            vid_req = ($urandom_range(15) == 0);
            vid_addr = 13'($urandom);
            if (cpu_ack || !cpu_req) begin
                cpu_req = ($urandom_range(2) == 0);
                cpu_we = 1'($urandom);
                cpu_byte = 1'($urandom);
                cpu_addr = 16'($urandom);
                cpu_wdata = 16'($urandom);
            end
            if (host_ack || !host_req) begin
                host_req = ($urandom_range(5) == 0);
                host_we = 1'($urandom);
                host_addr = 18'($urandom);
                host_wdata = 16'($urandom);
            end
`ifndef SRAM_SCHED_HOLD_EN
            host_hold = 1'($urandom);
`endif
        end
        vid_req = 0;
        cpu_req = 0;
        host_req = 0;
        repeat (12) @(negedge clk25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
